// File: rtl/axis_selector_sequencer_if.sv
// Control and status bundle between a sequencer and whatever programs it.
// The sequencer takes the slave view; the programming side takes the master view.
interface axis_selector_sequencer_if #(
    parameter int DWELL_WIDTH = 32
);
    logic                   enable;
    logic                   single_shot;
    logic [2:0]             num_slots;
    logic [DWELL_WIDTH-1:0] dwell;
    logic [15:0]            slot0_config;
    logic [15:0]            slot1_config;
    logic [15:0]            slot2_config;
    logic [15:0]            slot3_config;
    logic [31:0]            axis_selector;
    logic [1:0]             slot_index;
    logic                   blank;
    logic                   frame_done;
    logic                   busy;

    modport master (
        output enable, single_shot, num_slots, dwell,
               slot0_config, slot1_config, slot2_config, slot3_config,
        input  axis_selector, slot_index, blank, frame_done, busy
    );

    modport slave (
        input  enable, single_shot, num_slots, dwell,
               slot0_config, slot1_config, slot2_config, slot3_config,
        output axis_selector, slot_index, blank, frame_done, busy
    );
endinterface

// File: rtl/axis_selector_sequencer.sv
// Steps a 16-in/4-out AXIS selector through up to four routing words, each held
// for a programmable dwell, blanking the outputs while the mux settles.
module axis_selector_sequencer #(
    parameter int NSLOTS      = 4,
    parameter int DWELL_WIDTH = 32,
    parameter int SETTLE      = 2
) (
    input  logic                     a_clk,
    input  logic                     reset,
    axis_selector_sequencer_if.slave bus
);

    localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
    localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = DWELL_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_DWELL,
        S_DONE
    } state_e;

    state_e                 state_q,     state_d;
    logic [1:0]             idx_q,       idx_d;
    logic [15:0]            selWord_q,   selWord_d;
    logic [SW-1:0]          settleCnt_q, settleCnt_d;
    logic [DWELL_WIDTH-1:0] dwellCnt_q,  dwellCnt_d;
    logic [1:0]             nLast_q,     nLast_d;
    logic [DWELL_WIDTH-1:0] dLoad_q,     dLoad_d;

    logic [1:0]             nLastIn;
    logic [DWELL_WIDTH-1:0] dLoadIn;
    logic [1:0]             idxInc;
    logic [15:0]            cfgInc;
    logic                   frameDone;

    // Slot count and dwell are stored as "last index" and "reload value" so the
    // clamps (0 -> 1, above NSLOTS -> NSLOTS) are applied once at frame start.
    always_comb begin
        if (bus.num_slots == 3'd0) begin
            nLastIn = 2'd0;
        end else if (bus.num_slots > 3'(NSLOTS)) begin
            nLastIn = 2'(NSLOTS - 1);
        end else begin
            nLastIn = 2'(bus.num_slots - 3'd1);
        end
    end

    assign dLoadIn = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_ONE;
    assign idxInc  = idx_q + 2'd1;

    always_comb begin
        case (idxInc)
            2'd0:    cfgInc = bus.slot0_config;
            2'd1:    cfgInc = bus.slot1_config;
            2'd2:    cfgInc = bus.slot2_config;
            default: cfgInc = bus.slot3_config;
        endcase
    end

    always_ff @(posedge a_clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            selWord_q   <= '0;
            settleCnt_q <= '0;
            dwellCnt_q  <= '0;
            nLast_q     <= '0;
            dLoad_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            selWord_q   <= selWord_d;
            settleCnt_q <= settleCnt_d;
            dwellCnt_q  <= dwellCnt_d;
            nLast_q     <= nLast_d;
            dLoad_q     <= dLoad_d;
        end
    end

    // Each slot load enters the settle phase, or goes straight to dwell when no
    // settle window is configured; dropping enable aborts before any expiry.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        selWord_d   = selWord_q;
        settleCnt_d = settleCnt_q;
        dwellCnt_d  = dwellCnt_q;
        nLast_d     = nLast_q;
        dLoad_d     = dLoad_q;
        frameDone   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.enable) begin
                    nLast_d   = nLastIn;
                    dLoad_d   = dLoadIn;
                    idx_d     = 2'd0;
                    selWord_d = bus.slot0_config;
                    if (SETTLE == 0) begin
                        state_d    = S_DWELL;
                        dwellCnt_d = dLoadIn;
                    end else begin
                        state_d     = S_SETTLE;
                        settleCnt_d = SETTLE_LOAD;
                    end
                end
            end

            S_SETTLE: begin
                if (!bus.enable) begin
                    state_d = S_IDLE;
                end else if (settleCnt_q == '0) begin
                    state_d    = S_DWELL;
                    dwellCnt_d = dLoad_q;
                end else begin
                    settleCnt_d = settleCnt_q - SETTLE_ONE;
                end
            end

            S_DWELL: begin
                if (!bus.enable) begin
                    state_d = S_IDLE;
                end else if (dwellCnt_q != '0) begin
                    dwellCnt_d = dwellCnt_q - DWELL_ONE;
                end else if (idx_q != nLast_q) begin
                    idx_d     = idxInc;
                    selWord_d = cfgInc;
                    if (SETTLE == 0) begin
                        state_d    = S_DWELL;
                        dwellCnt_d = dLoad_q;
                    end else begin
                        state_d     = S_SETTLE;
                        settleCnt_d = SETTLE_LOAD;
                    end
                end else begin
                    frameDone = !reset;
                    if (bus.single_shot) begin
                        state_d = S_DONE;
                    end else begin
                        nLast_d   = nLastIn;
                        dLoad_d   = dLoadIn;
                        idx_d     = 2'd0;
                        selWord_d = bus.slot0_config;
                        if (SETTLE == 0) begin
                            state_d    = S_DWELL;
                            dwellCnt_d = dLoadIn;
                        end else begin
                            state_d     = S_SETTLE;
                            settleCnt_d = SETTLE_LOAD;
                        end
                    end
                end
            end

            S_DONE: begin
                if (!bus.enable) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.axis_selector = {16'h0000, selWord_q};
    assign bus.slot_index    = idx_q;
    assign bus.blank         = (state_q != S_DWELL);
    assign bus.busy          = (state_q == S_SETTLE) || (state_q == S_DWELL);
    assign bus.frame_done    = frameDone;

endmodule
